bnn_vad_engine: RTL
===================

# bnn_vad_engine

Parametrised binary-network voice-activity classifier. Accepts one MFCC window per handshake and applies CH 1-D conv kernels of TAPS taps. Binarises each conv output to ±1 and accumulates ±1 × FC-weight products per class over FRAMES windows. It then emits an argmax decision as a one-hot result. Sits between the MFCC front end and the VAD control logic; FC weights are held in an internal register file loaded through a write port.

## Interface
- DATA_W, 16, MFCC sample and conv weight width (signed)
- TAPS, 5, conv kernel length = samples per window
- CH, 3, conv channels
- FRAMES, 36, windows per decision
- CLASSES, 2, output classes (≥2)
- FCW_W, 3, FC weight width (signed)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  window present
- in_ready  out  1  engine accepts window
- in_data  in  TAPS*DATA_W  samples, tap 0 in LSBs, signed
- conv_wt  in  CH*TAPS*DATA_W  static conv kernels, ch-major, tap 0 in LSBs
- wt_we  in  1  FC weight write strobe
- wt_addr  in  $clog2(CLASSES*CH*FRAMES)  index = (class*CH + ch)*FRAMES + frame
- wt_data  in  FCW_W  signed FC weight
- result  out  CLASSES  one-hot decision
- result_valid  out  1  one-cycle pulse with new result
- busy  out  1  decision in progress (frame_cnt≠0 or draining)

## Operation
- FSM: RUN → DRAIN → DECIDE → RUN.
- RUN: in_ready=1; each handshake (in_valid & in_ready) registers CH conv sums into stage 1, with frame index f. After the FRAMES-th handshake, go to DRAIN.
- Conv: CONV_W = 2*DATA_W + $clog2(TAPS) signed; full precision, no saturation. sign_b[ch] = +1 if sum ≥ 0, else −1.
- MAC stage 2: acc[c] += Σch (sign_b[ch] ? +w : −w), with w = W[c][ch][f]. Negation is computed in ACC_W; no multiplier.
- ACC_W = FCW_W + $clog2(CH*FRAMES) + 1, signed. No overflow is possible, including w = −2^(FCW_W−1) under negation.
- DRAIN: one cycle; in_ready=0; the last MAC completes.
- DECIDE: one cycle; in_ready=0.
  - result ← one-hot of argmax(acc); ties go to the lowest class index.
  - result_valid pulses for one cycle. acc and frame_cnt clear to 0. Next state is RUN.
- result holds its value until the next decision.
- Weight writes are accepted in any state and take effect at the next edge. A read and a write to the same address in one cycle returns the old value. Out-of-range wt_addr is ignored.
- rst:
  - Clears FSM to RUN, frame_cnt, acc, and the pipeline valids.
  - result=0, result_valid=0, busy=0, in_ready=1 in the cycle after reset deasserts.
  - FC weights are not cleared.
  - Reset mid-decision discards the partial decision.
- in_valid while in_ready=0: the window is not consumed; the source holds it.

## Timing
- Last handshake at edge E: stage 1 at E+1, acc at E+2, result/result_valid registered at E+3.
- in_ready low for 2 cycles per decision. Peak throughput is FRAMES windows per FRAMES+2 cycles.
- conv_wt is sampled on each handshake edge; changing it mid-decision applies to subsequent frames only.

## Configuration
- BNN_BN_THRESH_EN defined:
  - Adds port conv_thr  in  CH*CONV_W  signed per-channel threshold.
  - sign_b[ch] = +1 iff sum ≥ conv_thr[ch], folding batch-norm into the threshold.
- Undefined: the port is absent and the threshold is constant 0.

## Structure
- Package bnn_vad_pkg holds:
  - width functions for CONV_W and ACC_W;
  - the FSM state enum (RUN, DRAIN, DECIDE);
  - the weight-address packing function.
- Sub-module bnn_conv_bin (one instance per channel, generate loop): TAPS-tap signed dot product, threshold, and sign output.
- The top level holds the handshake, FSM, FC register file, MAC, and argmax.

## Test plan
- Reset: assert rst for 2 cycles mid-run at frame 10 → result=0, busy=0, in_ready=1. The next 36 windows produce exactly one result_valid.
- All-positive:
  - in_data taps all +1, conv_wt all +1, W[1][*][*]=+3, W[0][*][*]=−1.
  - Result: acc1=324, acc0=−108 → result=2'b10, 3 cycles after the 36th handshake.
- Tie: all FC weights 0 → result=2'b01 (lowest index wins).
- Sign flip: conv_wt ch0 all −1 with positive data, W[0][0][*]=+2, others 0 → acc0=−72 < acc1=0 → result=2'b10.
- Backpressure:
  - Hold in_valid=1 continuously for 72 windows.
  - Observe in_ready=0 for exactly 2 cycles after each 36th handshake.
  - Observe two result_valid pulses, and no window lost or duplicated.
- Weight write during run: at frame 20, write W[1][2][30]=−4 → frame 30 uses −4. Extreme weight W=−4 with sign −1 gives +4 with no overflow.
- With BNN_BN_THRESH_EN: conv_thr ch0=100 with sum=99 → sign −1; sum=100 → sign +1.

Source files
------------

// File: rtl/bnn_vad_pkg.sv
// ============================================================================
// Module  : bnn_vad_pkg
// Brief   : Shared widths, FSM state encoding and FC weight-address packing
//           for the binary-network VAD classifier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bnn_vad_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        DECIDE = 2'd2
    } vad_state_t;

    // Full-precision width of a TAPS-tap signed dot product.
    function automatic int calc_conv_w(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

    // Extra sign bit keeps negation of the most negative weight in range.
    function automatic int calc_acc_w(input int fcw_w, input int ch, input int frames);
        return fcw_w + $clog2(ch * frames) + 1;
    endfunction

    function automatic int wt_index(input int cls, input int ch, input int frame,
                                    input int n_ch, input int frames);
        return (cls * n_ch + ch) * frames + frame;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_conv_bin.sv
// ============================================================================
// Module  : bnn_conv_bin
// Brief   : One conv channel: signed TAPS-tap dot product compared against a
//           threshold, producing the binarised sign (1 = +1, 0 = -1).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_conv_bin
    import bnn_vad_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAPS   = 5,
    parameter int CONV_W = calc_conv_w(DATA_W, TAPS)
) (
    input  logic [TAPS*DATA_W-1:0]  i_data,
    input  logic [TAPS*DATA_W-1:0]  i_wt,
    input  logic signed [CONV_W-1:0] i_thr,
    output logic                    o_sign
);

    logic signed [CONV_W-1:0] w_prod [TAPS];
    logic signed [CONV_W-1:0] w_sum;

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        logic signed [DATA_W-1:0] w_d;
        logic signed [DATA_W-1:0] w_w;
        assign w_d       = i_data[t*DATA_W +: DATA_W];
        assign w_w       = i_wt[t*DATA_W +: DATA_W];
        assign w_prod[t] = CONV_W'(w_d) * CONV_W'(w_w);
    end

    always_comb begin
        w_sum = '0;
        for (int t = 0; t < TAPS; t++) begin
            w_sum = w_sum + w_prod[t];
        end
    end

    assign o_sign = (w_sum >= i_thr);

endmodule

`default_nettype wire

// File: rtl/bnn_vad_engine.sv
// ============================================================================
// Module  : bnn_vad_engine
// Brief   : Binary-network VAD: per-window binarised conv, FC MAC over FRAMES
//           windows, one-hot argmax. Optional BNN_BN_THRESH_EN adds conv_thr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bnn_vad_engine
    import bnn_vad_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int TAPS    = 5,
    parameter int CH      = 3,
    parameter int FRAMES  = 36,
    parameter int CLASSES = 2,
    parameter int FCW_W   = 3,
    localparam int CONV_W = calc_conv_w(DATA_W, TAPS),
    localparam int WA_W   = $clog2(CLASSES * CH * FRAMES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [TAPS*DATA_W-1:0]    in_data,
    input  logic [CH*TAPS*DATA_W-1:0] conv_wt,
`ifdef BNN_BN_THRESH_EN
    input  logic [CH*CONV_W-1:0]      conv_thr,
`endif
    input  logic                      wt_we,
    input  logic [WA_W-1:0]           wt_addr,
    input  logic [FCW_W-1:0]          wt_data,
    output logic [CLASSES-1:0]        result,
    output logic                      result_valid,
    output logic                      busy
);

    localparam int ACC_W   = calc_acc_w(FCW_W, CH, FRAMES);
    localparam int c_DEPTH = CLASSES * CH * FRAMES;
    localparam int c_FR_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int c_CL_W  = $clog2(CLASSES);

    vad_state_t               r_state;
    vad_state_t               w_state_next;
    logic [c_FR_W-1:0]        r_frame_cnt;
    logic                     r_s1_valid;
    logic [CH-1:0]            r_s1_sign;
    logic [c_FR_W-1:0]        r_s1_frame;
    logic signed [ACC_W-1:0]  r_acc      [CLASSES];
    logic signed [ACC_W-1:0]  w_acc_next [CLASSES];
    logic signed [FCW_W-1:0]  r_fcw      [c_DEPTH];
    logic [WA_W-1:0]          w_idx;
    logic signed [ACC_W-1:0]  w_wext;
    logic [CH-1:0]            w_sign;
    logic                     w_hs;
    logic                     w_last;
    logic [c_CL_W-1:0]        w_best;
    logic signed [ACC_W-1:0]  w_best_val;
    logic [CLASSES-1:0]       w_onehot;

    assign w_hs   = in_valid & in_ready;
    assign w_last = (r_frame_cnt == c_FR_W'(FRAMES - 1));
    assign busy   = (r_frame_cnt != '0) || (r_state != RUN);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [CONV_W-1:0] w_thr;
`ifdef BNN_BN_THRESH_EN
        assign w_thr = conv_thr[c*CONV_W +: CONV_W];
`else
        assign w_thr = '0;
`endif
        bnn_conv_bin #(
            .DATA_W (DATA_W),
            .TAPS   (TAPS),
            .CONV_W (CONV_W)
        ) u_conv (
            .i_data (in_data),
            .i_wt   (conv_wt[c*TAPS*DATA_W +: TAPS*DATA_W]),
            .i_thr  (w_thr),
            .o_sign (w_sign[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    // in_ready is 1 throughout RUN, so in_valid alone qualifies the handshake here.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && w_last) w_state_next = DRAIN;
            end
            DRAIN:   w_state_next = DECIDE;
            DECIDE:  w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= '0;
            r_s1_frame  <= '0;
        end else begin
            r_s1_valid <= w_hs;
            if (w_hs) begin
                r_s1_sign   <= w_sign;
                r_s1_frame  <= r_frame_cnt;
                r_frame_cnt <= w_last ? '0 : r_frame_cnt + 1'b1;
            end else if (r_state == DECIDE) begin
                r_frame_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_idx  = '0;
        w_wext = '0;
        for (int k = 0; k < CLASSES; k++) begin
            w_acc_next[k] = r_acc[k];
            for (int c = 0; c < CH; c++) begin
                w_idx  = WA_W'(wt_index(k, c, int'(r_s1_frame), CH, FRAMES));
                w_wext = ACC_W'(r_fcw[w_idx]);
                w_acc_next[k] = r_s1_sign[c] ? (w_acc_next[k] + w_wext)
                                             : (w_acc_next[k] - w_wext);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state == DECIDE) begin
            for (int k = 0; k < CLASSES; k++) r_acc[k] <= '0;
        end else if (r_s1_valid) begin
            for (int k = 0; k < CLASSES; k++) r_acc[k] <= w_acc_next[k];
        end
    end

    // Weights survive reset; a same-edge read in the MAC sees the old value.
    always_ff @(posedge clk) begin
        if (wt_we && ({1'b0, wt_addr} < (WA_W + 1)'(c_DEPTH))) begin
            r_fcw[wt_addr] <= wt_data;
        end
    end

    // Strict > keeps the lowest index on ties.
    always_comb begin
        w_best     = '0;
        w_best_val = r_acc[0];
        for (int k = 1; k < CLASSES; k++) begin
            if (r_acc[k] > w_best_val) begin
                w_best_val = r_acc[k];
                w_best     = c_CL_W'(k);
            end
        end
        w_onehot         = '0;
        w_onehot[w_best] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= (r_state == DECIDE);
            if (r_state == DECIDE) result <= w_onehot;
        end
    end

endmodule

`default_nettype wire
